// File: rtl/set_assoc_cache_array.sv
// N-way set-associative cache storage: true-LRU ages, IDLE/LOOKUP/RESP lookup pipeline and a byte fill port.
// Optional macro CACHE_WRITE_BACK_EN adds per-line dirty tracking reported on victim_dirty.
module set_assoc_cache_array #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 7,
  parameter int OFFSET_W = 4,
  parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  parameter int WAYS     = 4,
  parameter int WAY_W    = $clog2(WAYS),
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              victim_valid,
  output logic              victim_dirty,
  output logic [TAG_W-1:0]  victim_tag,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [WAY_W-1:0]  fill_way,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              fill_last
);

  localparam int SETS = 2 ** INDEX_W;
  localparam int LINE = 2 ** OFFSET_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0]          data_q  [SETS][WAYS][LINE];
  logic [TAG_W-1:0]           tag_q   [SETS][WAYS];
  logic [WAYS-1:0]            valid_q [SETS];
  logic [WAYS-1:0][WAY_W-1:0] age_q   [SETS];

  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;

  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic [INDEX_W-1:0]  req_idx, fill_idx;
  logic [OFFSET_W-1:0] req_off, fill_off;

  assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx  = addr_q[OFFSET_W +: INDEX_W];
  assign req_off  = addr_q[OFFSET_W-1:0];
  assign fill_tag = fill_addr[ADDR_W-1 -: TAG_W];
  assign fill_idx = fill_addr[OFFSET_W +: INDEX_W];
  assign fill_off = fill_addr[OFFSET_W-1:0];

  logic lookup_en, req_acc, fill_acc;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_acc) state_d = LOOKUP;
      LOOKUP:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs; a pending fill byte takes the IDLE slot from a request
  always_comb begin
    req_ready  = 1'b0;
    fill_ready = 1'b0;
    resp_valid = 1'b0;
    lookup_en  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          fill_ready = 1'b1;
          req_ready  = !fill_valid;
        end
        LOOKUP:  lookup_en  = 1'b1;
        RESP:    resp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  assign req_acc  = req_valid && req_ready;
  assign fill_acc = fill_valid && fill_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (req_acc) begin
      addr_q  <= req_addr;
      write_q <= req_write;
      wdata_q <= req_wdata;
    end
  end

  // Tag match and victim selection for the captured request
  logic             hit, vic_inv;
  logic [WAY_W-1:0] hit_way, vic_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_inv = 1'b0;
    vic_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!vic_inv && !valid_q[req_idx][w]) begin
        vic_inv = 1'b1;
        vic_way = WAY_W'(w);
      end
    end
    if (!vic_inv) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age_q[req_idx][w] == WAY_W'(WAYS - 1)) vic_way = WAY_W'(w);
      end
    end
  end

  // Lookup and fill are never active together, so one age updater serves both
  logic                       age_en;
  logic [INDEX_W-1:0]         age_idx;
  logic [WAY_W-1:0]           age_way, age_old;
  logic [WAYS-1:0][WAY_W-1:0] age_new;

  always_comb begin
    age_en  = 1'b0;
    age_idx = fill_idx;
    age_way = fill_way;
    if (lookup_en && hit) begin
      age_en  = 1'b1;
      age_idx = req_idx;
      age_way = hit_way;
    end else if (fill_acc && fill_last) begin
      age_en  = 1'b1;
    end
    age_old = age_q[age_idx][age_way];
    for (int unsigned w = 0; w < WAYS; w++) begin
      age_new[w] = age_q[age_idx][w];
      if (WAY_W'(w) == age_way)             age_new[w] = '0;
      else if (age_q[age_idx][w] < age_old) age_new[w] = age_q[age_idx][w] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (fill_acc && fill_last) valid_q[fill_idx][fill_way] <= 1'b1;
      if (age_en) age_q[age_idx] <= age_new;
    end
  end

  // Data and tag storage are deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (fill_acc) begin
      data_q[fill_idx][fill_way][fill_off] <= fill_data;
      if (fill_last) tag_q[fill_idx][fill_way] <= fill_tag;
    end
    if (lookup_en && hit && write_q) data_q[req_idx][hit_way][req_off] <= wdata_q;
  end

  logic vic_dirty;

`ifdef CACHE_WRITE_BACK_EN
  logic [WAYS-1:0] dirty_q [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) dirty_q[s] <= '0;
    end else begin
      if (fill_acc && fill_last)        dirty_q[fill_idx][fill_way] <= 1'b0;
      if (lookup_en && hit && write_q)  dirty_q[req_idx][hit_way]   <= 1'b1;
    end
  end

  assign vic_dirty = dirty_q[req_idx][vic_way];
`else
  assign vic_dirty = 1'b0;
`endif

  logic              resp_hit_q, victim_valid_q, victim_dirty_q;
  logic [WAY_W-1:0]  resp_way_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic [TAG_W-1:0]  victim_tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_hit_q     <= 1'b0;
      resp_way_q     <= '0;
      resp_rdata_q   <= '0;
      victim_valid_q <= 1'b0;
      victim_dirty_q <= 1'b0;
      victim_tag_q   <= '0;
    end else if (lookup_en) begin
      resp_hit_q     <= hit;
      resp_way_q     <= hit ? hit_way : vic_way;
      resp_rdata_q   <= (hit && !write_q) ? data_q[req_idx][hit_way][req_off] : '0;
      victim_valid_q <= !hit && !vic_inv;
      victim_dirty_q <= !hit && !vic_inv && vic_dirty;
      victim_tag_q   <= (hit || vic_inv) ? '0 : tag_q[req_idx][vic_way];
    end
  end

  assign resp_hit     = resp_hit_q;
  assign resp_way     = resp_way_q;
  assign resp_rdata   = resp_rdata_q;
  assign victim_valid = victim_valid_q;
  assign victim_dirty = victim_dirty_q;
  assign victim_tag   = victim_tag_q;

endmodule

// File: tb/tb_set_assoc_cache_array.sv
// Randomised self-checking bench for set_assoc_cache_array against a recency-timestamp cache model.
module tb_set_assoc_cache_array;

  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 7;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAYS     = 4;
  localparam int WAY_W    = 2;
  localparam int DATA_W   = 8;
  localparam int SETS     = 1 << INDEX_W;
  localparam int LINE     = 1 << OFFSET_W;
`ifdef CACHE_WRITE_BACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              resp_valid, resp_hit, victim_valid, victim_dirty;
  logic [WAY_W-1:0]  resp_way;
  logic [DATA_W-1:0] resp_rdata;
  logic [TAG_W-1:0]  victim_tag;
  logic              fill_valid = 1'b0, fill_ready, fill_last = 1'b0;
  logic [WAY_W-1:0]  fill_way = '0;
  logic [ADDR_W-1:0] fill_addr = '0;
  logic [DATA_W-1:0] fill_data = '0;

  set_assoc_cache_array #(
    .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WAYS(WAYS), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_rdata(resp_rdata),
    .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_way(fill_way),
    .fill_addr(fill_addr), .fill_data(fill_data), .fill_last(fill_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: LRU is the way with the oldest last-use stamp
  logic [7:0]       m_data  [SETS][WAYS][LINE];
  logic [TAG_W-1:0] m_tag   [SETS][WAYS];
  bit               m_valid [SETS][WAYS];
  bit               m_dirty [SETS][WAYS];
  longint           m_use   [SETS][WAYS];
  longint           use_ctr = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_use[s][w]   = -longint'(w);
      end
  endfunction

  function automatic void touch(input int s, input int w);
    use_ctr++;
    m_use[s][w] = use_ctr;
  endfunction

  function automatic int lru_way(input int s);
    int v = 0;
    for (int w = 1; w < WAYS; w++) if (m_use[s][w] < m_use[s][v]) v = w;
    return v;
  endfunction

  function automatic logic [ADDR_W-1:0] mk_addr(input int t, input int s, input int o);
    logic [TAG_W-1:0]    tt = TAG_W'(t);
    logic [INDEX_W-1:0]  ii = INDEX_W'(s);
    logic [OFFSET_W-1:0] oo = OFFSET_W'(o);
    return {tt, ii, oo};
  endfunction

  function automatic void model_fill(input int w, input logic [ADDR_W-1:0] a,
                                     input logic [7:0] d, input bit last);
    int s = int'(a[OFFSET_W +: INDEX_W]);
    int o = int'(a[OFFSET_W-1:0]);
    m_data[s][w][o] = d;
    if (last) begin
      m_tag[s][w]   = a[ADDR_W-1 -: TAG_W];
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
      touch(s, w);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    fill_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_fill_ready", fill_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic fill_beat(input int w, input logic [ADDR_W-1:0] a, input logic [7:0] d, input bit last);
    int n = 0;
    fill_valid = 1'b1; fill_way = WAY_W'(w); fill_addr = a; fill_data = d; fill_last = last;
    @(negedge clk);
    while (!fill_ready && n < 20) begin n++; @(negedge clk); end
    if (!fill_ready) begin
      check("fill_ready_timeout", fill_ready, 1);
      fill_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    fill_valid = 1'b0; fill_last = 1'b0;
    model_fill(w, a, d, last);
  endtask

  // Completes a request already driven on req_*; checks latency, results and output hold
  task automatic req_finish(input string name, output int waited);
    int s, o, hw, v;
    logic [TAG_W-1:0] t;
    logic [7:0] exp_rd;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin waited++; @(negedge clk); end
    if (!req_ready) begin
      check({name, "_ready_timeout"}, req_ready, 1);
      req_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    s = int'(req_addr[OFFSET_W +: INDEX_W]);
    o = int'(req_addr[OFFSET_W-1:0]);
    t = req_addr[ADDR_W-1 -: TAG_W];
    hw = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    v = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
    if (v < 0) v = lru_way(s);
    exp_rd = (hw >= 0 && !req_write) ? m_data[s][hw][o] : 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check({name, "_lat_t1"}, resp_valid, 0);
    @(negedge clk);
    check({name, "_resp_valid"}, resp_valid, 1);
    check({name, "_hit"}, resp_hit, (hw >= 0) ? 1 : 0);
    check({name, "_way"}, resp_way, (hw >= 0) ? hw : v);
    check({name, "_rdata"}, resp_rdata, exp_rd);
    if (hw < 0) begin
      check({name, "_victim_valid"}, victim_valid, m_valid[s][v]);
      if (m_valid[s][v]) begin
        check({name, "_victim_tag"}, victim_tag, m_tag[s][v]);
        check({name, "_victim_dirty"}, victim_dirty, WB && m_dirty[s][v]);
      end
    end else begin
      if (req_write) begin
        m_data[s][hw][o] = req_wdata;
        m_dirty[s][hw] = 1'b1;
      end
      touch(s, hw);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_pulse_end"}, resp_valid, 0);
    check({name, "_way_hold"}, resp_way, (hw >= 0) ? hw : v);
    @(posedge clk); #1;
  endtask

  task automatic do_req(input string name, input logic [ADDR_W-1:0] a, input bit wr, input logic [7:0] wd);
    int waited;
    req_valid = 1'b1; req_addr = a; req_write = wr; req_wdata = wd;
    req_finish(name, waited);
  endtask

  // Fills a full line in random byte order; optionally slips a request to another set in mid-line
  task automatic fill_line(input int w, input int t, input int s, input bit shuffle, input bit interleave);
    int perm [LINE];
    for (int i = 0; i < LINE; i++) perm[i] = i;
    if (shuffle)
      for (int i = LINE - 1; i > 0; i--) begin
        int j = $urandom_range(0, i);
        int tmp = perm[i];
        perm[i] = perm[j];
        perm[j] = tmp;
      end
    for (int i = 0; i < LINE; i++) begin
      fill_beat(w, mk_addr(t, s, perm[i]), 8'($urandom), i == LINE - 1);
      if (interleave && i == LINE / 2)
        do_req("mid_fill_req", mk_addr($urandom_range(0, 5), (s + 1) % 4, $urandom_range(0, LINE - 1)),
               1'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int waited;
    do_reset();
    check("reset_resp_valid", resp_valid, 0);
    check("reset_resp_hit", resp_hit, 0);
    check("reset_resp_way", resp_way, 0);
    check("reset_resp_rdata", resp_rdata, 0);
    check("reset_victim_valid", victim_valid, 0);
    check("reset_victim_dirty", victim_dirty, 0);
    check("reset_victim_tag", victim_tag, 0);

    do_req("cold_read", 32'h0000_1230, 1'b0, 8'h00);

    fill_line(2, 5, 'h23, 1'b0, 1'b0);
    do_req("fill_hit", mk_addr(5, 'h23, 7), 1'b0, 8'h00);

    for (int w = 0; w < WAYS; w++) fill_line(w, 'h11 + w, 'h10, 1'b1, 1'b0);
    do_req("lru_evict", mk_addr('h20, 'h10, 0), 1'b0, 8'h00);

    do_req("write_hit", mk_addr('h11, 'h10, 3), 1'b1, 8'hA5);
    do_req("read_back", mk_addr('h11, 'h10, 3), 1'b0, 8'h00);
    for (int w = 1; w < WAYS; w++) do_req("age_touch", mk_addr('h11 + w, 'h10, w), 1'b0, 8'h00);
    do_req("dirty_evict", mk_addr('h20, 'h10, 0), 1'b0, 8'h00);

    // Fill byte and request raised together: fill wins, request goes next cycle
    fill_valid = 1'b1; fill_way = 2'd1; fill_addr = mk_addr(9, 'h40, 0); fill_data = 8'h3C; fill_last = 1'b0;
    req_valid = 1'b1; req_addr = mk_addr('h14, 'h10, 2); req_write = 1'b0;
    @(negedge clk);
    check("conc_req_ready", req_ready, 0);
    check("conc_fill_ready", fill_ready, 1);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    model_fill(1, mk_addr(9, 'h40, 0), 8'h3C, 1'b0);
    req_finish("conc_req", waited);
    check("conc_req_wait", waited, 0);

    // Reset while the lookup is in flight
    req_valid = 1'b1; req_addr = mk_addr('h13, 'h10, 1); req_write = 1'b0;
    @(negedge clk);
    check("rl_accept_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rl_resp_valid_in_rst", resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rl_no_resp", resp_valid, 0);
    end
    @(posedge clk); #1;
    do_req("rl_read_miss", mk_addr('h13, 'h10, 1), 1'b0, 8'h00);

    for (int it = 0; it < 160; it++) begin
      int s = $urandom_range(0, 3);
      int t = $urandom_range(0, 5);
      if ($urandom_range(0, 3) == 0) begin
        int w = $urandom_range(0, WAYS - 1);
        for (int ww = 0; ww < WAYS; ww++) if (m_valid[s][ww] && m_tag[s][ww] == TAG_W'(t)) w = ww;
        fill_line(w, t, s, 1'b1, $urandom_range(0, 1) == 1);
      end else begin
        do_req("rand_req", mk_addr(t, s, $urandom_range(0, LINE - 1)), 1'($urandom), 8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
